// File: rtl/maxpool_pkg.sv
// Shared types and default dimensions for the 2x2 / stride-2 max-pool sequencer.
// The optional stall counter in the top is enabled by MAXPOOL_STALL_CNT_EN.
package maxpool_pkg;

  localparam int MP_IN_WIDTH  = 8;
  localparam int MP_IN_HEIGHT = 8;
  localparam int MP_ADDR_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One stage of the tag pipeline that follows a pixel through the datapath.
  typedef struct packed {
    logic                 valid;
    logic [MP_ADDR_W-1:0] r;
    logic [MP_ADDR_W-1:0] c;
  } tag_t;

  localparam tag_t TAG_EMPTY = '0;

  // A tag closes a stride-2 window only on the odd row and odd column.
  function automatic logic closes_window(input tag_t t);
    return t.valid & t.r[0] & t.c[0];
  endfunction

endpackage

// File: rtl/maxpool_scan_ctrl_raster_addr_gen.sv
// Raster-order row/col counter pair for the max-pool scan controller.
// Advances one column per 'advance', wraps the column at COLS-1 and bumps the
// row; the row saturates at ROWS-1. 'clear' restarts the scan at (0,0).
module raster_addr_gen
  import maxpool_pkg::*;
#(
  parameter int COLS   = MP_IN_WIDTH,
  parameter int ROWS   = MP_IN_HEIGHT,
  parameter int ADDR_W = MP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              last
);

  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic              col_end;
  logic              row_end;

  // Next-count logic: clear wins, otherwise step in raster order on advance.
  always_comb begin
    col_end = (col_q == ADDR_W'(COLS - 1));
    row_end = (row_q == ADDR_W'(ROWS - 1));
    row_d   = row_q;
    col_d   = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_end) begin
        col_d = '0;
        if (!row_end) begin
          row_d = row_q + ADDR_W'(1);
        end
      end else begin
        col_d = col_q + ADDR_W'(1);
      end
    end
  end

  // Counter registers, cleared by the active-low asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = col_end & row_end;

endmodule

// File: rtl/maxpool_scan_ctrl.sv
// Sequencer for the 2x2 / stride-2 max-pooling datapath: walks the input map in
// raster order, issues pixel-buffer reads, gates the datapath shift and flags
// valid pooled windows, honouring writeback backpressure.
// Define MAXPOOL_STALL_CNT_EN to add the stall_cycles counter output.
module maxpool_scan_ctrl
  import maxpool_pkg::*;
#(
  parameter int IN_WIDTH  = MP_IN_WIDTH,
  parameter int IN_HEIGHT = MP_IN_HEIGHT,
  parameter int ADDR_W    = MP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              read_pixel_signal,
  output logic [ADDR_W-1:0] read_row_addr,
  output logic [ADDR_W-1:0] read_col_addr,
  output logic              shift_en,
  output logic              save_enable,
  input  logic              save_ready,
  output logic [ADDR_W-1:0] output_row,
  output logic [ADDR_W-1:0] output_col,
  output logic              busy,
`ifdef MAXPOOL_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              layer_done
);

  state_t            state_q, state_d;
  tag_t              a_q, a_d;
  tag_t              b_q, b_d;
  logic              stall;
  logic              issue;
  logic              clear;
  logic [ADDR_W-1:0] cnt_row;
  logic [ADDR_W-1:0] cnt_col;
  logic              cnt_last;

  raster_addr_gen #(
    .COLS   (IN_WIDTH),
    .ROWS   (IN_HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (issue),
    .row     (cnt_row),
    .col     (cnt_col),
    .last    (cnt_last)
  );

  // Handshake decode: a pending save that writeback refuses freezes the whole scan.
  always_comb begin
    save_enable = closes_window(b_q);
    stall       = save_enable & ~save_ready;
    issue       = (state_q == RUN) & ~stall;
    shift_en    = a_q.valid & ~stall;
  end

  // FSM next state and per-state outputs; start is only heard in IDLE.
  always_comb begin
    state_d    = state_q;
    layer_done = 1'b0;
    clear      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (issue && cnt_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!a_q.valid && !stall) begin
          state_d = DONE;
        end
      end
      DONE: begin
        layer_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag pipeline: A tracks the pixel arriving from the buffer, B the pixel in the window.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (!stall) begin
      a_d.valid = issue;
      a_d.r     = MP_ADDR_W'(cnt_row);
      a_d.c     = MP_ADDR_W'(cnt_col);
      b_d       = a_q;
    end
  end

  // State and tag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= TAG_EMPTY;
      b_q     <= TAG_EMPTY;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign read_pixel_signal = issue;
  assign read_row_addr     = cnt_row;
  assign read_col_addr     = cnt_col;
  assign output_row        = ADDR_W'(b_q.r >> 1);
  assign output_col        = ADDR_W'(b_q.c >> 1);
  assign busy              = (state_q != IDLE);

`ifdef MAXPOOL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of backpressure cycles, restarted when a frame is accepted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clear) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_maxpool_scan_ctrl.sv
// Self-checking bench for maxpool_scan_ctrl: a 4x4 instance for directed frame
// timing, stall, ignored-start and reset-abort cases, and a default 8x8 instance
// under random writeback backpressure. Cycle 0 is the cycle start is driven high.
module tb_maxpool_scan_ctrl;

   logic clk = 1'b0;
   logic rst4, start4, ready4;
   logic rst8, start8, ready8;

   logic        read4, shift4, save4, busy4, done4;
   logic [15:0] rowA4, colA4, orow4, ocol4;
   logic        read8, shift8, save8, busy8, done8;
   logic [15:0] rowA8, colA8, orow8, ocol8;
`ifdef MAXPOOL_STALL_CNT_EN
   logic [31:0] stall4, stall8;
`endif

   int testsRun = 0;
   int testsFailed = 0;

   int nReads, firstRead, lastRead, nSaves, nDone, doneCyc, lastBusy;
   int readWhileStall, shiftWhileStall, heldCycles, heldMoved, zeroAtReset;
   int stallAtDone, stallAtCyc0, stallAtCyc1, nStalls, tbStallsAtDone;
   int saveCyc[64];
   int saveRow[64];
   int saveCol[64];

   always #5 clk = ~clk;

   maxpool_scan_ctrl #(.IN_WIDTH(4), .IN_HEIGHT(4), .ADDR_W(16)) dut4 (
      .clk(clk), .rst(rst4), .start(start4),
      .read_pixel_signal(read4), .read_row_addr(rowA4), .read_col_addr(colA4),
      .shift_en(shift4), .save_enable(save4), .save_ready(ready4),
      .output_row(orow4), .output_col(ocol4), .busy(busy4),
`ifdef MAXPOOL_STALL_CNT_EN
      .stall_cycles(stall4),
`endif
      .layer_done(done4)
   );

   maxpool_scan_ctrl #(.IN_WIDTH(8), .IN_HEIGHT(8), .ADDR_W(16)) dut8 (
      .clk(clk), .rst(rst8), .start(start8),
      .read_pixel_signal(read8), .read_row_addr(rowA8), .read_col_addr(colA8),
      .shift_en(shift8), .save_enable(save8), .save_ready(ready8),
      .output_row(orow8), .output_col(ocol8), .busy(busy8),
`ifdef MAXPOOL_STALL_CNT_EN
      .stall_cycles(stall8),
`endif
      .layer_done(done8)
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Clears the per-frame event recorders.
   task automatic clearRecord();
      nReads = 0; firstRead = -1; lastRead = -1; nSaves = 0; nDone = 0;
      doneCyc = -1; lastBusy = -1; readWhileStall = 0; shiftWhileStall = 0;
      heldCycles = 0; heldMoved = 0; zeroAtReset = -1; stallAtDone = -1;
      stallAtCyc0 = -1; stallAtCyc1 = -1; nStalls = 0; tbStallsAtDone = -1;
   endtask

   // Drives one 4x4 frame (start at cycle 0) and records what the DUT does.
   // Entered and left just after a rising edge.
   task automatic applyStimulus(input int loFrom, input int loTo, input int extraA,
                                input int extraB, input int rstAt, input int rstRel,
                                input int nCycles);
      int prevRow, prevCol;
      logic prevStall;
      logic stall;
      clearRecord();
      prevStall = 1'b0; prevRow = 0; prevCol = 0;
      for (int cyc = 0; cyc < nCycles; cyc++) begin
         start4 = (cyc == 0) || (cyc == extraA) || (cyc == extraB);
         ready4 = !((cyc >= loFrom) && (cyc <= loTo));
         if (cyc == rstAt) rst4 = 1'b0;
         if (cyc == rstRel) rst4 = 1'b1;
         @(negedge clk);
         stall = save4 && !ready4;
         if (read4) begin
            nReads++;
            if (firstRead < 0) firstRead = cyc;
            lastRead = cyc;
            if (stall) readWhileStall++;
         end
         if (shift4 && stall) shiftWhileStall++;
         if (stall) begin
            heldCycles++;
            if (prevStall && ((int'(orow4) != prevRow) || (int'(ocol4) != prevCol))) heldMoved++;
         end
         if (save4 && ready4 && nSaves < 64) begin
            saveCyc[nSaves] = cyc; saveRow[nSaves] = int'(orow4); saveCol[nSaves] = int'(ocol4);
            nSaves++;
         end
         if (busy4) lastBusy = cyc;
         if (done4) begin
            nDone++;
            doneCyc = cyc;
`ifdef MAXPOOL_STALL_CNT_EN
            stallAtDone = int'(stall4);
`endif
         end
`ifdef MAXPOOL_STALL_CNT_EN
         if (cyc == 0) stallAtCyc0 = int'(stall4);
         if (cyc == 1) stallAtCyc1 = int'(stall4);
`endif
         if (cyc == rstAt) begin
            zeroAtReset = (read4 || shift4 || save4 || busy4 || done4 || (|rowA4) ||
                           (|colA4) || (|orow4) || (|ocol4)) ? 0 : 1;
         end
         prevStall = stall; prevRow = int'(orow4); prevCol = int'(ocol4);
         @(posedge clk);
         #1;
      end
      start4 = 1'b0;
      ready4 = 1'b1;
   endtask

   // Runs one 8x8 frame with random writeback readiness until layer_done or a cycle budget.
   task automatic applyRandomFrame(input int budget);
      logic stall;
      clearRecord();
      for (int cyc = 0; cyc < budget; cyc++) begin
         start8 = (cyc == 0);
         ready8 = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         stall = save8 && !ready8;
         if (read8) begin
            nReads++;
            if (stall) readWhileStall++;
         end
         if (shift8 && stall) shiftWhileStall++;
         if (save8 && ready8 && nSaves < 64) begin
            saveRow[nSaves] = int'(orow8); saveCol[nSaves] = int'(ocol8);
            nSaves++;
         end
         if (done8) begin
            nDone++;
            doneCyc = cyc;
            tbStallsAtDone = nStalls;
`ifdef MAXPOOL_STALL_CNT_EN
            stallAtDone = int'(stall8);
`endif
         end
         if (stall) nStalls++;
         @(posedge clk);
         #1;
         if (doneCyc >= 0 && cyc > doneCyc + 3) break;
      end
      start8 = 1'b0;
      ready8 = 1'b1;
   endtask

   initial begin
      int expCyc[4];
      int expRow[4];
      int expCol[4];
      int orderErr;

      expRow = '{0, 0, 1, 1};
      expCol = '{0, 1, 0, 1};

      rst4 = 1'b0; rst8 = 1'b0;
      start4 = 1'b0; start8 = 1'b0;
      ready4 = 1'b1; ready8 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy", int'(busy4), 0);
      checkOutput("reset read", int'(read4), 0);
      checkOutput("reset save/shift/done", int'(save4 | shift4 | done4), 0);
      checkOutput("reset coords", int'(orow4 | ocol4 | rowA4 | colA4), 0);
      @(posedge clk);
      #1;
      rst4 = 1'b1; rst8 = 1'b1;
      @(posedge clk);
      #1;

      // Plain 4x4 frame, writeback always ready.
      $display("[TB] 4x4 frame, no stall");
      applyStimulus(-1, -1, -1, -1, -1, -1, 30);
      checkOutput("s1 reads", nReads, 16);
      checkOutput("s1 first read", firstRead, 1);
      checkOutput("s1 last read", lastRead, 16);
      checkOutput("s1 saves", nSaves, 4);
      expCyc = '{8, 10, 16, 18};
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("s1 save%0d cycle", k), saveCyc[k], expCyc[k]);
         checkOutput($sformatf("s1 save%0d row", k), saveRow[k], expRow[k]);
         checkOutput($sformatf("s1 save%0d col", k), saveCol[k], expCol[k]);
      end
      checkOutput("s1 done count", nDone, 1);
      checkOutput("s1 done cycle", doneCyc, 19);
      checkOutput("s1 last busy", lastBusy, 19);
`ifdef MAXPOOL_STALL_CNT_EN
      checkOutput("s1 stall_cycles", stallAtDone, 0);
`endif

      // Same frame with writeback refusing cycles 8-11.
      $display("[TB] 4x4 frame, save_ready low cycles 8-11");
      applyStimulus(8, 11, -1, -1, -1, -1, 30);
      checkOutput("s2 reads", nReads, 16);
      checkOutput("s2 last read", lastRead, 20);
      checkOutput("s2 read while stalled", readWhileStall, 0);
      checkOutput("s2 shift while stalled", shiftWhileStall, 0);
      checkOutput("s2 stalled cycles", heldCycles, 4);
      checkOutput("s2 coords moved in stall", heldMoved, 0);
      checkOutput("s2 saves", nSaves, 4);
      expCyc = '{12, 14, 20, 22};
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("s2 save%0d cycle", k), saveCyc[k], expCyc[k]);
         checkOutput($sformatf("s2 save%0d row", k), saveRow[k], expRow[k]);
         checkOutput($sformatf("s2 save%0d col", k), saveCol[k], expCol[k]);
      end
      checkOutput("s2 done cycle", doneCyc, 23);
`ifdef MAXPOOL_STALL_CNT_EN
      checkOutput("s2 stall_cycles", stallAtDone, 4);
`endif

      // Extra start pulses mid-frame and coincident with layer_done.
      $display("[TB] 4x4 frame, extra starts at 5 and 19");
      applyStimulus(-1, -1, 5, 19, -1, -1, 30);
      checkOutput("s3 reads", nReads, 16);
      checkOutput("s3 saves", nSaves, 4);
      checkOutput("s3 done count", nDone, 1);
      checkOutput("s3 done cycle", doneCyc, 19);
      checkOutput("s3 last busy", lastBusy, 19);
`ifdef MAXPOOL_STALL_CNT_EN
      checkOutput("s3 stall_cycles before start", stallAtCyc0, 4);
      checkOutput("s3 stall_cycles cleared", stallAtCyc1, 0);
`endif

      // Reset asserted at cycle 10 and released at 12 aborts the frame.
      $display("[TB] 4x4 frame, reset abort at cycle 10");
      applyStimulus(-1, -1, -1, -1, 10, 12, 30);
      checkOutput("s4 outputs zero in reset", zeroAtReset, 1);
      checkOutput("s4 reads before abort", nReads, 9);
      checkOutput("s4 last busy", lastBusy, 9);
      checkOutput("s4 no done", nDone, 0);

      $display("[TB] 4x4 frame after abort");
      applyStimulus(-1, -1, -1, -1, -1, -1, 30);
      checkOutput("s4b reads", nReads, 16);
      checkOutput("s4b first read", firstRead, 1);
      checkOutput("s4b saves", nSaves, 4);
      checkOutput("s4b save0 cycle", saveCyc[0], 8);
      checkOutput("s4b save0 row", saveRow[0], 0);
      checkOutput("s4b save0 col", saveCol[0], 0);
      checkOutput("s4b done cycle", doneCyc, 19);

      // Default 8x8 map under random backpressure.
      $display("[TB] 8x8 frame, random save_ready");
      applyRandomFrame(1500);
      checkOutput("s5 done count", nDone, 1);
      checkOutput("s5 reads", nReads, 64);
      checkOutput("s5 saves", nSaves, 16);
      checkOutput("s5 read while stalled", readWhileStall, 0);
      checkOutput("s5 shift while stalled", shiftWhileStall, 0);
      orderErr = 0;
      for (int k = 0; k < 16; k++) begin
         if (k < nSaves && (saveRow[k] != k / 4 || saveCol[k] != k % 4)) orderErr++;
      end
      checkOutput("s5 raster order errors", orderErr, 0);
`ifdef MAXPOOL_STALL_CNT_EN
      checkOutput("s5 stall_cycles", stallAtDone, tbStallsAtDone);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Hard stop in case the bench itself gets stuck.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
